// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and pointer-width helper
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_THRESH = 1;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: unreset storage array, synchronous write port, asynchronous read port
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock show-ahead FIFO with status/error flags; FIFO_PEAK_EN adds a peak-occupancy register
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   write,
  input  logic                   read,
  input  logic                   clr_err,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] peak
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AF_THRESH > DEPTH) || (AE_THRESH > DEPTH)) begin : g_bad_cfg
    $error("sync_fifo_param: DEPTH must be a power of two >= 2 and thresholds <= DEPTH");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok;
  assign empty        = count == '0;
  assign full         = count == CW'(DEPTH);
  assign almost_full  = count >= CW'(AF_THRESH);
  assign almost_empty = count <= CW'(AE_THRESH);
  assign rd_ok        = read && !empty;
  assign wr_ok        = write && (!full || rd_ok);
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (data_out)
  );
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(wr_ok) - CW'(rd_ok);
      overflow  <= (overflow && !clr_err) || (write && !wr_ok);
      underflow <= (underflow && !clr_err) || (read && !rd_ok);
    end
`ifdef FIFO_PEAK_EN
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) peak <= '0;
    else       peak <= clr_err ? count : (count > peak ? count : peak);
`else
  assign peak = '0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized + directed scoreboard bench against a queue reference model
module tb_sync_fifo_param;
  localparam int W   = 8;
  localparam int D   = 8;
  localparam int AFT = D - 2;
  localparam int AET = 1;
  localparam int CW  = $clog2(D) + 1;
  logic clk = 0, clrn = 0, write = 0, read = 0, clr_err = 0;
  logic [W-1:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count, peak;
  int total = 0, passed = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  int m_peak = 0;
  bit m_ovf = 0, m_udf = 0;
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .write        (write),
    .read         (read),
    .clr_err      (clr_err),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .peak         (peak)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  // one clock of stimulus; entered and left at posedge+1 so the model is settled before the negedge monitor
  task automatic cycle(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    bit ra, wa, n_ovf, n_udf;
    int n_peak;
    write = w; read = r; clr_err = c; data_in = d;
    ra = r && mq.size() > 0;
    wa = w && (mq.size() < D || ra);
    n_ovf = (m_ovf && !c) || (w && !wa);
    n_udf = (m_udf && !c) || (r && !ra);
`ifdef FIFO_PEAK_EN
    n_peak = c ? mq.size() : (mq.size() > m_peak ? mq.size() : m_peak);
`else
    n_peak = 0;
`endif
    if (ra) exp_q.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(d);
    m_ovf = n_ovf; m_udf = n_udf; m_peak = n_peak;
    write = 0; read = 0; clr_err = 0;
  endtask
  always @(negedge clk)
    if (clrn) begin
      chk("count", count, mq.size());
      chk("full", full, mq.size() == D);
      chk("empty", empty, mq.size() == 0);
      chk("almost_full", almost_full, mq.size() >= AFT);
      chk("almost_empty", almost_empty, mq.size() <= AET);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
      chk("peak", peak, m_peak);
      if (read && !empty) begin
        if (exp_q.size() == 0) chk("unexpected_read_data", 1, 0);
        else chk("data_out", data_out, exp_q.pop_front());
      end
    end
  initial begin
    #12 clrn = 1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) cycle(1, 0, 0, W'(i));
    cycle(1, 0, 0, 8'h09);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 1, '0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, W'(8'h10 + i));
    cycle(1, 1, 0, 8'hAA);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);
    cycle(1, 1, 0, 8'h55);
    chk("empty_rw_data", data_out, 8'h55);
    cycle(0, 1, 1, '0);
    for (int k = 0; k < 20; k++) begin
      cycle(1, 0, 0, W'(8'h30 + k));
      chk("wrap_count_le2", count <= 2, 1);
      cycle(0, 1, 0, '0);
    end
    cycle(0, 0, 1, '0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, W'(8'h60 + i));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);
`ifdef FIFO_PEAK_EN
    chk("peak_after_5", peak, 5);
`else
    chk("peak_after_5", peak, 0);
`endif
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, W'(8'h70 + i));
    write = 1; data_in = 8'h7F;
    #2 clrn = 0;
    mq.delete(); exp_q.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_peak", peak, 0);
    @(posedge clk); #1;
    write = 0; clrn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(99) < 55, $urandom_range(99) < 50, $urandom_range(99) < 4, W'($urandom));
    while (mq.size() > 0) cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for byte- and word-wide streaming paths, with configurable data width and depth. Every one of the DEPTH entries is usable. Adds full/empty flags, programmable almost-full and almost-empty flags, an occupancy count, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in the same clock domain and is the general-purpose buffer for new designs.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserted when count ≥ AF_THRESH
- AE_THRESH, 1, almost_empty asserted when count ≤ AE_THRESH
- clk  in  1  clock, rising edge
- clrn  in  1  reset clrn, asynchronous, active-low
- write  in  1  write request, active high
- read  in  1  read request, active high
- clr_err  in  1  synchronous clear of overflow/underflow
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  head-of-queue word (show-ahead)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was rejected
- peak  out  $clog2(DEPTH)+1  maximum occupancy since reset/clr_err (see Configuration)

## Operation
- Pointers wr_ptr and rd_ptr are AW = $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked in a separate register. Full is decided from count, never from pointer equality.
- Write is accepted when write && (!full || read_accepted). An accepted write stores data_in at wr_ptr, then wr_ptr increments.
- Read is accepted when read && !empty. An accepted read increments rd_ptr. Data is not presented on a later cycle: the consumer samples data_out in the same cycle it asserts read.
- count updates as follows:
  - +1 on an accepted write only
  - -1 on an accepted read only
  - unchanged when both are accepted, or when neither is
- Full + read + write in the same cycle: both are accepted. count stays DEPTH. No overflow is flagged.
- Empty + read + write in the same cycle: the write is accepted and the read is rejected. underflow is set. count becomes 1.
- A write that is not accepted sets overflow. A read that is not accepted sets underflow. Both flags hold until clr_err or reset.
- clr_err in the same cycle as a new error: the error wins and the flag stays 1.
- data_out = mem[rd_ptr] (combinational). When empty, data_out is undefined and is not checked.
- Storage has no reset. Contents are undefined after reset.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0, peak=0.
- An assertion of clrn mid-operation clears all state immediately and asynchronously. Queued data is discarded.
- Status outputs full, empty, almost_*, count, overflow and underflow are registered or derived from registered count. All of them update on the clock edge after the accepted operation.
- Write-to-read latency: a word written at edge N is visible on data_out after edge N, and is readable in cycle N+1.
- No combinational path from read or write to any status output.

## Configuration
- Macro FIFO_PEAK_EN.
- Defined:
  - peak register tracks max(count) and updates one cycle after count.
  - clr_err loads peak with the current count.
- Undefined: peak is tied to 0 and no register is inferred. The port is always present.

## Structure
- Shared package fifo_pkg holds:
  - the function computing pointer width from DEPTH
  - the default threshold constants
- Sub-module sync_fifo_mem: WIDTH×DEPTH array with one synchronous write port and one asynchronous read port. It has no reset. Top level holds pointers, count, flags and the optional peak register.
- Elaboration check: DEPTH must be a power of two, and AF_THRESH/AE_THRESH must be ≤ DEPTH.

## Test plan
- Reset, then 8 writes of 0x01..0x08 (DEPTH=8): full=1 after the 8th edge, count=8, almost_full=1 from count 6, overflow=0.
- 9th write while full: overflow=1, count stays 8. Then 8 reads return 0x01..0x08 in order, empty=1 after the last read, and overflow is still 1 until a clr_err pulse clears it.
- While full, assert read and write together with data 0xAA: count stays 8, overflow=0, and 0xAA is the last word read out.
- While empty, assert read and write together with 0x55: underflow=1, count=1, data_out=0x55 next cycle.
- Wrap-around: 20 interleaved write/read pairs with incrementing data: data order preserved across pointer wrap, and count never exceeds 2.
- With FIFO_PEAK_EN: 5 writes then 5 reads give peak=5. Asserting clrn mid-burst gives count=0, empty=1 and peak=0. Without the macro, peak stays 0 throughout.
